sm_clk_gen: RTL and testbench
=============================

# sm_clk_gen

Parametrised successor of the board clock divider: produces the CPU clock `clkOut` from `clkIn` with a glitch-free power-of-two divide that may change at any time, a clock-enable freeze, and a single-step mode that issues exactly one full `clkOut` period per `step` button press. It sits between the input debouncers and the CPU/RAM in the hardware top level. It also provides a `tick` strobe in the `clkIn` domain.

## Interface
- `MAX_DIV`, default 24: largest honoured divide exponent; larger requests clamp to `MAX_DIV`.
- `DIV_W`, default 5: width of `divide`.
- `CNT_W`, default 25: half-period counter width; must satisfy 2^CNT_W > 2^MAX_DIV − 1.
- `clkIn` in 1: sole clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: 0 freezes the counter and FSM; `clkOut` holds its level.
- `divide` in DIV_W: half-period = 2^min(divide, MAX_DIV) `clkIn` cycles. Already debounced.
- `stepMode` in 1: 0 = free-run, 1 = single-step.
- `step` in 1: asynchronous step button, synchronised internally.
- `clkOut` out 1: registered divided clock.
- `tick` out 1: one-`clkIn`-cycle strobe coinciding with the first cycle of each `clkOut` high phase.
- `busy` out 1: high while a `clkOut` period is in progress (FSM state HIGH or LOW).

## Operation
- FSM states:
  - IDLE (`clkOut`=0)
  - HIGH (`clkOut`=1)
  - LOW (`clkOut`=0)
- Transitions, evaluated only when `enable`=1:
  - IDLE→HIGH when `stepMode`=0, or when `stepMode`=1 and a synchronised rising edge of `step` is seen.
  - HIGH→LOW when `cnt` == `limit`.
  - LOW→HIGH when `cnt` == `limit` and `stepMode`=0.
  - LOW→IDLE when `cnt` == `limit` and `stepMode`=1.
- `limit` = 2^d − 1, where d = min(`divide`, `MAX_DIV`).
  - `limit` is latched into `limReg` on entry to HIGH and on entry to LOW.
  - A `divide` change mid-phase therefore affects only the next phase; no runt pulses.
- `cnt`:
  - Cleared on every state entry.
  - Increments by 1 each enabled cycle in HIGH or LOW.
  - Held at 0 in IDLE.
- `stepMode` rising while running: the current period completes through LOW, then the FSM goes to IDLE.
- `stepMode` falling while IDLE or in a step period: free-running starts or continues at the next boundary.
- `step` edges arriving while `busy`=1 or `enable`=0 are discarded, not queued.
- `divide`=0: each phase lasts 1 cycle, so `clkOut` = `clkIn`/2.

## Timing
- Reset values: `clkOut`=0, `tick`=0, `busy`=0, state IDLE, `cnt`=0, `limReg`=0, synchroniser flops 0.
- Reset is asynchronous at assertion. Asserting it mid-phase forces these values immediately.
- Free-run start: with `enable`=1 and `stepMode`=0 in IDLE at edge k, `clkOut`=1 and `tick`=1 after edge k+1.
- Each phase lasts exactly 2^d `clkIn` cycles; the period is 2^(d+1) cycles.
- `step` latency: 2-flop sync plus 1 edge register.
  - A `step` rise that meets setup before edge k gives `clkOut`=1 after edge k+3.
  - `clkOut` is low again after 2^(d+1) cycles in total.
- `enable`=0 for N cycles stretches the current phase by exactly N cycles.
  - `tick` is not re-issued.
- `tick` and `clkOut` are both registered outputs, with no combinational path from inputs.

## Structure
- Package `sm_clk_pkg`:
  - FSM state enumeration (IDLE/HIGH/LOW, 2-bit).
  - A function computing `limit` from `divide` with clamping.
- Sub-module `sm_sync_edge`: 2-flop synchroniser plus rising-edge detector, reset by `rst_n`, 1-cycle pulse output. Used for `step`.

## Test plan
- Reset: hold `rst_n`=0, then release with `stepMode`=1 → `clkOut`=`tick`=`busy`=0 and IDLE indefinitely.
- Free-run at `divide`=0 → `clkOut` toggles every cycle.
- Free-run at `divide`=3 → 8 high / 8 low, with `tick` once per 16 cycles.
- Divide change: switch `divide` from 3 to 1 in the 4th cycle of a high phase → that phase stays 8 cycles, the following phases are 2 cycles.
- Clamp: run with `divide`=31 and `MAX_DIV`=4 → 16-cycle phases.
- Step: `stepMode`=1, `divide`=2, one `step` pulse:
  - Exactly one period: 4 high + 4 low, first high 3 cycles after the sampled edge.
  - A second `step` pulse during `busy` gives no extra period.
- Freeze and reset: drop `enable` for 5 cycles mid-HIGH → the high phase lasts 2^d+5 cycles. Then assert `rst_n`=0 asynchronously mid-LOW → outputs go to 0 before the next `clkIn` edge.

Source files
------------

// File: rtl/sm_clk_pkg.sv
// Shared types and helpers for the CPU clock generator.
package sm_clk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } clkState_t;

   // Half-period terminal count: 2^min(divide, maxDiv) - 1.
   function automatic logic [31:0] calcLimit(input logic [31:0] divide,
                                             input logic [31:0] maxDiv);
      logic [31:0] d;
      if (divide > maxDiv) begin
         d = maxDiv;
      end else begin
         d = divide;
      end
      calcLimit = (32'd1 << d) - 32'd1;
   endfunction

endpackage

// File: rtl/sm_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// rising-edge detector producing a single-cycle pulse.
module sm_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic sync1_r;
   logic sync2_r;
   logic prev_r;
   logic pulse_r;

   // Synchroniser chain, edge history and registered edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         pulse_r <= sync2_r & ~prev_r;
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/sm_clk_gen.sv
// CPU clock generator: glitch-free power-of-two divider with clock-enable
// freeze and single-step mode, plus a tick strobe in the clkIn domain.
module sm_clk_gen
   import sm_clk_pkg::*;
#(
   parameter int MAX_DIV = 24,
   parameter int DIV_W   = 5,
   parameter int CNT_W   = 25
) (
   input  logic             clkIn,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] divide,
   input  logic             stepMode,
   input  logic             step,
   output logic             clkOut,
   output logic             tick,
   output logic             busy
);

   clkState_t        state_r;
   clkState_t        nextState_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] limReg_r;
   logic [CNT_W-1:0] limit_s;
   logic             cntDone_s;
   logic             stepPulse_s;
   logic             clkOut_r;
   logic             tick_r;
   logic             busy_r;
   logic             clkOutNext_s;
   logic             tickNext_s;
   logic             busyNext_s;

   sm_sync_edge u_stepSync (
      .clk   (clkIn),
      .rst_n (rst_n),
      .din   (step),
      .pulse (stepPulse_s)
   );

   assign limit_s   = CNT_W'(calcLimit(32'(divide), 32'(MAX_DIV)));
   assign cntDone_s = (cnt_r == limReg_r);

   // State register.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state logic; a disabled cycle freezes the FSM where it is.
   always_comb begin
      nextState_s = state_r;
      if (enable) begin
         case (state_r)
            IDLE: begin
               if (!stepMode || stepPulse_s) begin
                  nextState_s = HIGH;
               end else begin
                  nextState_s = IDLE;
               end
            end
            HIGH: begin
               if (cntDone_s) begin
                  nextState_s = LOW;
               end else begin
                  nextState_s = HIGH;
               end
            end
            LOW: begin
               if (cntDone_s) begin
                  nextState_s = stepMode ? IDLE : HIGH;
               end else begin
                  nextState_s = LOW;
               end
            end
            default: nextState_s = IDLE;
         endcase
      end else begin
         nextState_s = state_r;
      end
   end

   // Phase counter and limit latch; limit only moves at phase entry so a
   // divide change never shortens a phase already in progress.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CNT_W{1'b0}};
         limReg_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         if (nextState_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
            if ((nextState_s == HIGH) || (nextState_s == LOW)) begin
               limReg_r <= limit_s;
            end
         end else if (state_r == IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Output decode from the upcoming state so the outputs can be registered.
   always_comb begin
      clkOutNext_s = 1'b0;
      busyNext_s   = 1'b0;
      tickNext_s   = 1'b0;
      case (nextState_s)
         IDLE: begin
            clkOutNext_s = 1'b0;
            busyNext_s   = 1'b0;
         end
         HIGH: begin
            clkOutNext_s = 1'b1;
            busyNext_s   = 1'b1;
         end
         LOW: begin
            clkOutNext_s = 1'b0;
            busyNext_s   = 1'b1;
         end
         default: begin
            clkOutNext_s = 1'b0;
            busyNext_s   = 1'b0;
         end
      endcase
      if ((nextState_s == HIGH) && (state_r != HIGH)) begin
         tickNext_s = 1'b1;
      end else begin
         tickNext_s = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         clkOut_r <= 1'b0;
         tick_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         clkOut_r <= clkOutNext_s;
         tick_r   <= tickNext_s;
         busy_r   <= busyNext_s;
      end
   end

   assign clkOut = clkOut_r;
   assign tick   = tick_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_sm_clk_gen.sv
// Self-checking bench for sm_clk_gen: phase-time model compared every cycle
// plus directed measurements of phase lengths, step latency and reset.
module tb_sm_clk_gen;

   localparam int MAXD = 4;

   logic       clkIn = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [4:0] divide;
   logic       stepMode;
   logic       step;
   logic       clkOut;
   logic       tick;
   logic       busy;

   int errors = 0;
   int checks = 0;
   bit checkOn = 1'b0;

   always #5 clkIn = ~clkIn;

   sm_clk_gen #(.MAX_DIV(MAXD), .DIV_W(5), .CNT_W(5)) dut (
      .clkIn    (clkIn),
      .rst_n    (rst_n),
      .enable   (enable),
      .divide   (divide),
      .stepMode (stepMode),
      .step     (step),
      .clkOut   (clkOut),
      .tick     (tick),
      .busy     (busy)
   );

   function automatic int phaseLen(input logic [4:0] dv);
      int d;
      d = (int'(dv) > MAXD) ? MAXD : int'(dv);
      return 1 << d;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: running/high flags and cycles left in the current phase.
   bit         mRun;
   bit         mHigh;
   bit         mTick;
   int         mLeft;
   logic [3:0] stepHist;

   always @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         mRun <= 1'b0; mHigh <= 1'b0; mTick <= 1'b0; mLeft <= 0; stepHist <= 4'd0;
      end else begin
         stepHist <= {stepHist[2:0], step};
         if (!enable) begin
            mTick <= 1'b0;
         end else if (!mRun) begin
            if (!stepMode || (stepHist[2] && !stepHist[3])) begin
               mRun <= 1'b1; mHigh <= 1'b1; mTick <= 1'b1; mLeft <= phaseLen(divide);
            end else begin
               mTick <= 1'b0;
            end
         end else if (mLeft > 1) begin
            mLeft <= mLeft - 1; mTick <= 1'b0;
         end else if (mHigh) begin
            mHigh <= 1'b0; mTick <= 1'b0; mLeft <= phaseLen(divide);
         end else if (!stepMode) begin
            mHigh <= 1'b1; mTick <= 1'b1; mLeft <= phaseLen(divide);
         end else begin
            mRun <= 1'b0; mTick <= 1'b0;
         end
      end
   end

   always @(negedge clkIn) begin
      if (checkOn) begin
         check("model_clkOut", int'(clkOut), int'(mRun && mHigh));
         check("model_tick",   int'(tick),   int'(mTick));
         check("model_busy",   int'(busy),   int'(mRun));
      end
   end

   task automatic waitLevel(input logic lvl, input string name);
      int n;
      n = 0;
      while (clkOut !== lvl && n < 200) begin
         @(negedge clkIn);
         n++;
      end
      check(name, int'(clkOut === lvl), 1);
   endtask

   task automatic countLevel(input logic lvl, output int n, output int ticks);
      n = 0;
      ticks = 0;
      while (clkOut === lvl && n < 200) begin
         n++;
         ticks += int'(tick);
         @(negedge clkIn);
      end
   endtask

   task automatic measurePeriod(output int hi, output int lo, output int tk);
      int t2;
      waitLevel(1'b0, "wait_low");
      waitLevel(1'b1, "wait_high");
      countLevel(1'b1, hi, tk);
      countLevel(1'b0, lo, t2);
   endtask

   initial begin
      int hi, lo, tk, n, busyCnt, hiCnt;
      rst_n = 1'b0; enable = 1'b1; stepMode = 1'b1; step = 1'b0; divide = 5'd0;
      repeat (3) @(negedge clkIn);
      check("rst_clkOut", int'(clkOut), 0);
      check("rst_tick",   int'(tick),   0);
      check("rst_busy",   int'(busy),   0);
      rst_n = 1'b1;
      checkOn = 1'b1;
      repeat (12) @(negedge clkIn);
      check("idle_clkOut", int'(clkOut), 0);
      check("idle_busy",   int'(busy),   0);

      // Free-run at divide=0.
      stepMode = 1'b0;
      @(negedge clkIn);
      check("start_clkOut", int'(clkOut), 1);
      check("start_tick",   int'(tick),   1);
      @(negedge clkIn);
      check("d0_low", int'(clkOut), 0);
      measurePeriod(hi, lo, tk);
      check("d0_hi", hi, 1);
      check("d0_lo", lo, 1);
      check("d0_tick", tk, 1);

      // divide=3: 8 high / 8 low, one tick per period.
      divide = 5'd3;
      measurePeriod(hi, lo, tk);
      check("d3_hi", hi, 8);
      check("d3_lo", lo, 8);
      check("d3_tick", tk, 1);

      // Switch to divide=1 in the 4th cycle of a high phase.
      repeat (3) @(negedge clkIn);
      divide = 5'd1;
      countLevel(1'b1, n, tk);
      check("chg_hi_kept", 3 + n, 8);
      countLevel(1'b0, n, tk);
      check("chg_lo", n, 2);
      countLevel(1'b1, n, tk);
      check("chg_hi_next", n, 2);

      // Clamp: divide=31 with MAX_DIV=4.
      divide = 5'd31;
      measurePeriod(hi, lo, tk);
      check("clamp_hi", hi, 16);
      check("clamp_lo", lo, 16);

      // Single step at divide=2.
      stepMode = 1'b1;
      divide = 5'd2;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clkIn);
         n++;
      end
      check("step_idle_reached", int'(busy === 1'b0), 1);
      repeat (3) @(negedge clkIn);
      step = 1'b1;
      n = 0;
      @(negedge clkIn);
      while (clkOut === 1'b0 && n < 20) begin
         n++;
         if (n == 2) step = 1'b0;
         @(negedge clkIn);
      end
      check("step_latency", n, 3);
      step = 1'b1;
      countLevel(1'b1, n, tk);
      step = 1'b0;
      check("step_hi", n, 4);
      check("step_tick", tk, 1);
      busyCnt = 0;
      hiCnt = 0;
      for (int i = 0; i < 30; i++) begin
         busyCnt += int'(busy);
         hiCnt += int'(clkOut);
         @(negedge clkIn);
      end
      check("step_busy_cycles", busyCnt, 4);
      check("step_no_extra", hiCnt, 0);

      // Freeze 5 cycles mid-HIGH at divide=2.
      stepMode = 1'b0;
      waitLevel(1'b1, "frz_start");
      @(negedge clkIn);
      enable = 1'b0;
      repeat (5) @(negedge clkIn);
      enable = 1'b1;
      countLevel(1'b1, n, tk);
      check("frz_hi", 6 + n, 9);
      check("frz_no_tick", tk, 0);

      // Asynchronous reset mid-LOW.
      @(negedge clkIn);
      check("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_clkOut", int'(clkOut), 0);
      check("arst_tick",   int'(tick),   0);
      check("arst_busy",   int'(busy),   0);
      stepMode = 1'b1;
      @(negedge clkIn);
      rst_n = 1'b1;
      repeat (6) @(negedge clkIn);
      check("post_rst_idle", int'(busy), 0);
      checkOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
